sram_1r1w: RTL and testbench

Parametrised one-read/one-write SRAM model, successor to the team's single-port array. Adds independent read and write ports, active-low byte write enables, a registered and optionally double-registered read path with a valid strobe, and write-first collision bypass. An optional post-reset sweep zeroes the array. It serves as the buffer macro model for accumulator and activation storage in the accelerator datapath.

---
 rtl/sram_1r1w.sv | 111 +++++++++++
 tb/tb_sram_1r1w.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w.sv
// One-read/one-write SRAM model: byte-masked writes, write-first bypass,
// 1- or 2-cycle registered read path with valid strobe, optional zeroing sweep.

module sram_lane #(
  parameter int W = 8
) (
  input  logic [W-1:0] old,
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] y
);
  assign y = en ? d : old;
endmodule

module sram_1r1w #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 2048,
  parameter int ADDR_BITS      = 11,
  parameter int BYTE_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = WIDTH / BYTE_W
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 CEN_R,
  input  logic [ADDR_BITS-1:0] A_R,
  input  logic                 CEN_W,
  input  logic [ADDR_BITS-1:0] A_W,
  input  logic [WIDTH-1:0]     D,
  input  logic [NB-1:0]        BWEN,
  output logic [WIDTH-1:0]     Q,
  output logic                 QV,
  output logic                 BUSY
);
  localparam int STAGES = OUT_REG;
  localparam logic [ADDR_BITS:0]   DEPTH_X = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST    = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] cnt;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic rd_req, rd_hit, wr_hit, collide;
  logic [NB-1:0][BYTE_W-1:0] rd_old, wr_old, d_l, rd_mrg, wr_mrg;

  assign BUSY    = (state == S_CLEAR);
  assign rd_req  = !CEN_R && !BUSY;
  assign rd_hit  = rd_req && ({1'b0, A_R} < DEPTH_X);
  assign wr_hit  = !CEN_W && !BUSY && ({1'b0, A_W} < DEPTH_X);
  assign collide = rd_hit && wr_hit && (A_R == A_W);

  // Out-of-range reads see an all-zero old word, so they return 0.
  assign rd_old = rd_hit ? mem[A_R] : '0;
  assign wr_old = mem[A_W];
  assign d_l    = D;

  genvar i;
  generate
    for (i = 0; i < NB; i++) begin : g_lane
      sram_lane #(.W(BYTE_W)) u_rd (
        .old(rd_old[i]), .d(d_l[i]), .en(collide && !BWEN[i]), .y(rd_mrg[i])
      );
      sram_lane #(.W(BYTE_W)) u_wr (
        .old(wr_old[i]), .d(d_l[i]), .en(!BWEN[i]), .y(wr_mrg[i])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt   <= '0;
    end else if (state == S_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= S_RUN;
    end
  end

  // Array storage carries no reset; the sweep zeroes it instead.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      if (BUSY)        mem[cnt] <= '0;
      else if (wr_hit) mem[A_W] <= wr_mrg;
    end
  end

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;

  // Data stages load only behind a valid so Q holds between reads.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_req;
      if (rd_req) dat_pipe[0] <= rd_mrg;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign Q  = dat_pipe[STAGES];
  assign QV = vld_pipe[STAGES];

endmodule

// File: tb/tb_sram_1r1w.sv
// Bench for sram_1r1w: three instances (16-deep lat1, 16-deep lat2, 12-deep lat1)
// on shared stimulus, each scored against a reference array model.

module tb_sram_1r1w;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        cen_r = 1'b1, cen_w = 1'b1;
  logic [3:0]  a_r = '0, a_w = '0, bwen = '1;
  logic [31:0] d = '0;
  logic [31:0] q0, q1, q2;
  logic        qv0, qv1, qv2, busy0, busy1, busy2;

  int n_cmp = 0, n_err = 0;
  logic [31:0] m16 [16];
  logic [31:0] m12 [12];
  logic [31:0] sb0 [$], sb1 [$], sb2 [$];

  always #5 clk = ~clk;

  sram_1r1w #(.WIDTH(32), .DEPTH(16), .ADDR_BITS(4), .BYTE_W(8), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .CLK(clk), .RSTN(rstn), .CEN_R(cen_r), .A_R(a_r), .CEN_W(cen_w), .A_W(a_w),
    .D(d), .BWEN(bwen), .Q(q0), .QV(qv0), .BUSY(busy0));
  sram_1r1w #(.WIDTH(32), .DEPTH(16), .ADDR_BITS(4), .BYTE_W(8), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .CLK(clk), .RSTN(rstn), .CEN_R(cen_r), .A_R(a_r), .CEN_W(cen_w), .A_W(a_w),
    .D(d), .BWEN(bwen), .Q(q1), .QV(qv1), .BUSY(busy1));
  sram_1r1w #(.WIDTH(32), .DEPTH(12), .ADDR_BITS(4), .BYTE_W(8), .OUT_REG(0), .CLEAR_ON_RESET(1)) u2 (
    .CLK(clk), .RSTN(rstn), .CEN_R(cen_r), .A_R(a_r), .CEN_W(cen_w), .A_W(a_w),
    .D(d), .BWEN(bwen), .Q(q2), .QV(qv2), .BUSY(busy2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] bw);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = bw[i] ? old[i*8 +: 8] : wd[i*8 +: 8];
    return r;
  endfunction

  // Drive one cycle of requests, record expected read data, advance to next negedge.
  task automatic cyc(input logic ren, input logic [3:0] ra, input logic wen, input logic [3:0] wa,
                     input logic [31:0] wd, input logic [3:0] bw);
    logic [31:0] nw, e;
    cen_r = ~ren; a_r = ra; cen_w = ~wen; a_w = wa; d = wd; bwen = bw;
    if (!busy0) begin
      nw = merge(m16[wa], wd, bw);
      if (ren) begin
        e = (wen && ra == wa) ? nw : m16[ra];
        sb0.push_back(e); sb1.push_back(e);
      end
      if (wen) m16[wa] = nw;
    end
    if (!busy2) begin
      nw = (wa < 4'd12) ? merge(m12[wa], wd, bw) : 32'h0;
      if (ren) begin
        if (ra >= 4'd12)            e = 32'h0;
        else if (wen && ra == wa)   e = nw;
        else                        e = m12[ra];
        sb2.push_back(e);
      end
      if (wen && wa < 4'd12) m12[wa] = nw;
    end
    @(posedge clk);
    @(negedge clk);
    cen_r = 1'b1; cen_w = 1'b1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) m16[i] = '0;
    for (int i = 0; i < 12; i++) m12[i] = '0;
  endtask

  task automatic run_sweep(input string tag);
    int n16 = 0, n12 = 0, guard = 0;
    while ((busy0 || busy2) && guard < 40) begin
      if (busy0) n16++;
      if (busy2) n12++;
      guard++;
      cyc(1'b1, 4'(guard), 1'b1, 4'(guard), 32'hC0DE0000 + 32'(guard), 4'b0000);
    end
    check({tag, "_busy16"}, 32'(n16), 32'd16);
    check({tag, "_busy12"}, 32'(n12), 32'd12);
  endtask

  always @(negedge clk) if (rstn) begin
    if (qv0) begin
      if (sb0.size() == 0) check("u0_spurious_qv", 32'(qv0), 32'd0);
      else                 check("u0_q", q0, sb0.pop_front());
    end
    if (qv1) begin
      if (sb1.size() == 0) check("u1_spurious_qv", 32'(qv1), 32'd0);
      else                 check("u1_q", q1, sb1.pop_front());
    end
    if (qv2) begin
      if (sb2.size() == 0) check("u2_spurious_qv", 32'(qv2), 32'd0);
      else                 check("u2_q", q2, sb2.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    zero_model();
    repeat (3) @(negedge clk);
    check("rst_q0", q0, 32'h0);
    check("rst_qv0", 32'(qv0), 32'h0);
    check("rst_busy0", 32'(busy0), 32'h1);
    check("rst_q1", q1, 32'h0);
    check("rst_busy2", 32'(busy2), 32'h1);
    rstn = 1'b1;
    run_sweep("sweep1");

    for (int a = 0; a < 16; a++) cyc(1'b1, 4'(a), 1'b0, 4'h0, 32'h0, 4'hF);

    // Byte mask
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0000);
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 32'h11223344, 4'b1010);
    cyc(1'b1, 4'd5, 1'b0, 4'd0, 32'h0, 4'hF);
    check("bytemask_u0", q0, 32'hAA22CC44);

    // Latency and hold
    cyc(1'b0, 4'd0, 1'b1, 4'd3, 32'h12345678, 4'b0000);
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 32'h0, 4'hF);
    check("lat1_qv", 32'(qv0), 32'h1);
    check("lat1_q", q0, 32'h12345678);
    check("lat2_qv_early", 32'(qv1), 32'h0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 4'hF);
    check("lat2_qv", 32'(qv1), 32'h1);
    check("lat2_q", q1, 32'h12345678);
    check("lat1_hold_qv", 32'(qv0), 32'h0);
    check("lat1_hold_q", q0, 32'h12345678);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 4'hF);
    check("lat2_hold_qv", 32'(qv1), 32'h0);
    check("lat2_hold_q", q1, 32'h12345678);

    // Write-first collision
    cyc(1'b0, 4'd0, 1'b1, 4'd7, 32'hFFFFFFFF, 4'b0000);
    cyc(1'b1, 4'd7, 1'b1, 4'd7, 32'h00000000, 4'b1100);
    check("coll_u0", q0, 32'hFFFF0000);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 4'hF);
    check("coll_u1", q1, 32'hFFFF0000);
    cyc(1'b1, 4'd7, 1'b0, 4'd0, 32'h0, 4'hF);
    check("coll_later", q0, 32'hFFFF0000);

    // Out-of-range on the 12-deep instance, back-to-back reads
    cyc(1'b0, 4'd0, 1'b1, 4'd0,  32'hA0A0A0A0, 4'b0000);
    cyc(1'b0, 4'd0, 1'b1, 4'd1,  32'hB1B1B1B1, 4'b0000);
    cyc(1'b0, 4'd0, 1'b1, 4'd13, 32'hDEADBEEF, 4'b0000);
    cyc(1'b1, 4'd0, 1'b0, 4'd0, 32'h0, 4'hF);
    check("oor_qv_a", 32'(qv2), 32'h1);
    check("oor_q_a", q2, 32'hA0A0A0A0);
    cyc(1'b1, 4'd13, 1'b0, 4'd0, 32'h0, 4'hF);
    check("oor_qv_b", 32'(qv2), 32'h1);
    check("oor_q_b", q2, 32'h0);
    check("inrange_u0_13", q0, 32'hDEADBEEF);
    cyc(1'b1, 4'd1, 1'b0, 4'd0, 32'h0, 4'hF);
    check("oor_qv_c", 32'(qv2), 32'h1);
    check("oor_q_c", q2, 32'hB1B1B1B1);
    for (int a = 0; a < 16; a++) cyc(1'b1, 4'(a), 1'b0, 4'h0, 32'h0, 4'hF);

    // Mixed random traffic
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), $urandom, 4'($urandom));
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 4'hF);
    check("drain_u0", 32'(sb0.size()), 32'd0);
    check("drain_u1", 32'(sb1.size()), 32'd0);
    check("drain_u2", 32'(sb2.size()), 32'd0);

    // Reset with a read in flight in the 2-stage instance
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 32'h0, 4'hF);
    #2 rstn = 1'b0;
    #1;
    check("rstrd_q1", q1, 32'h0);
    check("rstrd_qv1", 32'(qv1), 32'h0);
    check("rstrd_q0", q0, 32'h0);
    check("rstrd_qv0", 32'(qv0), 32'h0);
    sb0.delete(); sb1.delete(); sb2.delete();
    zero_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reset six cycles into the sweep, then a full sweep again
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i), 1'b1, 4'(i), 32'h5A5A5A5A, 4'b0000);
    check("midsweep_busy", 32'(busy0), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("midsweep_q1", q1, 32'h0);
    check("midsweep_qv1", 32'(qv1), 32'h0);
    check("midsweep_busy_rst", 32'(busy1), 32'h1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_sweep("sweep2");

    cyc(1'b1, 4'd3, 1'b1, 4'd2, 32'h600DF00D, 4'b0000);
    check("post_q3_zero", q0, 32'h0);
    cyc(1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 4'hF);
    check("post_q2", q0, 32'h600DF00D);
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 4'hF);
    check("drain2_u0", 32'(sb0.size()), 32'd0);
    check("drain2_u1", 32'(sb1.size()), 32'd0);
    check("drain2_u2", 32'(sb2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
